pll_lock_supervisor: RTL
========================

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter PLL_RESET_CYCLES, default 16: cycles the PLL RESETB input is held low per reset pulse, range 1..65535.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 4096: cycles allowed for lock before the PLL is re-reset, range 1..65535.
REQ-003 SHALL have parameter STABLE_CYCLES, default 256: consecutive synchronized-lock-high cycles required, range 1..65535.
REQ-004 SHALL have parameter HOLD_CYCLES, default 64: extra cycles sys_reset stays asserted after lock is stable, range 1..65535.
REQ-005 SHALL have port clk, input, 1 bit: reference clock, the PLL input clock, not the PLL output clock.
REQ-006 SHALL have port reset, input, 1 bit: synchronous reset, active high.
REQ-007 SHALL have port pll_lock, input, 1 bit: PLL LOCK output, asynchronous to clk.
REQ-008 SHALL have port pll_resetb, output, 1 bit: drives PLL RESETB, active low.
REQ-009 SHALL have port sys_reset, output, 1 bit: active-high reset for logic clocked by the PLL output.
REQ-010 SHALL have port locked, output, 1 bit: high only in RUN.
REQ-011 SHALL have port relock_count, output, 8 bits: saturating count of lock losses and lock timeouts.

Function
REQ-012 SHALL pass pll_lock through a 2-flop synchronizer to form lock_s; only lock_s is used internally.
REQ-013 SHALL implement states PLLRST, WAITLOCK, STABLE, HOLD and RUN, with one shared 16-bit down/up counter cleared on every state entry.
REQ-014 PLLRST: pll_resetb=0; after PLL_RESET_CYCLES cycles the block SHALL go to WAITLOCK.
REQ-015 WAITLOCK: pll_resetb=1; lock_s=1 SHALL go to STABLE; LOCK_TIMEOUT cycles without lock_s SHALL go to PLLRST and increment relock_count.
REQ-016 STABLE: lock_s=0 SHALL return to WAITLOCK (timeout counter restarts, no increment); STABLE_CYCLES consecutive lock_s=1 cycles SHALL go to HOLD.
REQ-017 HOLD: lock_s=0 SHALL go to PLLRST and increment relock_count; after HOLD_CYCLES cycles the block SHALL go to RUN.
REQ-018 RUN: lock_s=0 SHALL go to PLLRST and increment relock_count.
REQ-019 sys_reset SHALL be registered: 1 in every state except RUN; it SHALL rise on the same edge that leaves RUN.
REQ-020 sys_reset SHALL fall STABLE_CYCLES+HOLD_CYCLES+2 clk edges after the first edge that samples pll_lock=1, given continuous lock from WAITLOCK.
REQ-021 relock_count SHALL saturate at 255, with no wrap.
REQ-022 When a timeout and lock_s rising occur on the same cycle in WAITLOCK, lock_s SHALL win (go to STABLE).
REQ-023 Downstream logic SHALL synchronize sys_reset into the PLL output domain; this block SHALL provide no cross-domain logic.

Reset
REQ-024 reset=1 SHALL force, on the next edge: state PLLRST, counter 0, pll_resetb=0, sys_reset=1, locked=0, relock_count=0, synchronizer flops 0.
REQ-025 reset asserted mid-operation, including in RUN, SHALL restart the full sequence from PLLRST without incrementing relock_count.

Configuration
REQ-026 With macro PLL_SUPERVISOR_RELOCK_COUNT_EN defined, relock_count SHALL behave per REQ-015..REQ-018 and REQ-021.
REQ-027 Without PLL_SUPERVISOR_RELOCK_COUNT_EN, relock_count SHALL be constant 0, no counter register SHALL be synthesized, and the state machine SHALL be unchanged.

Verification
REQ-028 Default parameters, reset released, pll_lock rises 100 cycles after pll_resetb rises and stays high -> pll_resetb low for exactly 16 cycles; sys_reset falls 322 edges after lock is first sampled; locked=1; relock_count=0.
REQ-029 pll_lock never asserted -> pll_resetb pulses low for 16 cycles every 4112 cycles; relock_count increments at each timeout; sys_reset stays 1.
REQ-030 In RUN, drop pll_lock for 1 cycle -> sys_reset=1 and locked=0 within 3 cycles; relock_count=1; full sequence repeats.
REQ-031 Glitch pll_lock low for 1 cycle at STABLE count 200 -> STABLE restarts; sys_reset falls 322 edges after lock is re-sampled high; relock_count=0.
REQ-032 Force 300 lock losses -> relock_count holds 255; with the macro undefined, relock_count stays 0 throughout.
REQ-033 Assert reset for 1 cycle in RUN -> next edge gives sys_reset=1 and pll_resetb=0; relock_count=0.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset/lock sequencer generating a held system reset.
// Optional relock counter enabled by defining PLL_SUPERVISOR_RELOCK_COUNT_EN.
module pll_lock_supervisor #(
    parameter int PLL_RESET_CYCLES = 16,
    parameter int LOCK_TIMEOUT     = 4096,
    parameter int STABLE_CYCLES    = 256,
    parameter int HOLD_CYCLES      = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_resetb,
    output logic       sys_reset,
    output logic       locked,
    output logic [7:0] relock_count
);

    typedef enum logic [2:0] {
        PLLRST   = 3'd0,
        WAITLOCK = 3'd1,
        STABLE   = 3'd2,
        HOLD     = 3'd3,
        RUN      = 3'd4
    } state_t;

    localparam logic [15:0] RST_LAST    = 16'(PLL_RESET_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       lock_s;
    state_t     state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic       pll_resetb_q, pll_resetb_d;
    logic       sys_reset_q, sys_reset_d;
    logic       locked_q, locked_d;

    assign lock_s = sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            state_q      <= PLLRST;
            cnt_q        <= 16'd0;
            pll_resetb_q <= 1'b0;
            sys_reset_q  <= 1'b1;
            locked_q     <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pll_resetb_q <= pll_resetb_d;
            sys_reset_q  <= sys_reset_d;
            locked_q     <= locked_d;
        end
    end

    always_comb begin
        sync1_d = pll_lock;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        case (state_q)
            PLLRST: begin
                if (cnt_q == RST_LAST) state_d = WAITLOCK;
            end
            WAITLOCK: begin
                // Lock takes priority over a coincident timeout.
                if (lock_s)                      state_d = STABLE;
                else if (cnt_q == TIMEOUT_LAST)  state_d = PLLRST;
            end
            STABLE: begin
                if (!lock_s)                     state_d = WAITLOCK;
                else if (cnt_q == STABLE_LAST)   state_d = HOLD;
            end
            HOLD: begin
                if (!lock_s)                     state_d = PLLRST;
                else if (cnt_q == HOLD_LAST)     state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q;
                if (!lock_s) state_d = PLLRST;
            end
            default: state_d = PLLRST;
        endcase
        if (state_d != state_q) cnt_d = 16'd0;

        // Outputs are registered from the next state so they change on the transition edge.
        pll_resetb_d = (state_d != PLLRST);
        sys_reset_d  = (state_d != RUN);
        locked_d     = (state_d == RUN);
    end

    assign pll_resetb = pll_resetb_q;
    assign sys_reset  = sys_reset_q;
    assign locked     = locked_q;

`ifdef PLL_SUPERVISOR_RELOCK_COUNT_EN
    logic [7:0] relock_q, relock_d;
    logic       relock_inc;

    // Any non-reset entry into PLLRST from another state is a timeout or a lock loss.
    always_comb begin
        relock_inc = (state_q != PLLRST) && (state_d == PLLRST);
        relock_d   = relock_q;
        if (relock_inc && (relock_q != 8'hff)) relock_d = relock_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) relock_q <= 8'd0;
        else       relock_q <= relock_d;
    end

    assign relock_count = relock_q;
`else
    assign relock_count = 8'd0;
`endif

endmodule
